branch_pc_unit: RTL and testbench
=================================

Name: branch_pc_unit

Overview:
- Owns the 32-bit program counter and resolves conditional branches, downstream of the CON flag flip-flop stage.
- The control sequencer issues either an increment request (fetch) or a branch request.
- On a branch request the block strobes CON_input and waits for the registered CON flag to settle.
- It then loads either PC + sign-extended C offset (taken) or leaves PC unchanged (not taken), and drives the PC onto the bus on request.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- OFFSET_W, 19, width of branch displacement field C (IR[18:0]).
- INC_STEP, 1, amount added to PC on an increment request.

Ports:
- clock  in  1  system clock, rising edge.
- clear  in  1  asynchronous active-high reset.
- inc_req  in  1  single-cycle pulse: PC <= PC + INC_STEP.
- br_req  in  1  single-cycle pulse: start branch resolution.
- offset  in  OFFSET_W  IR C field; sampled on br_req.
- con_flag  in  1  CON_output from the CON flag stage.
- con_strobe  out  1  drives CON_input of the CON flag stage.
- pc  out  32  current PC.
- busy  out  1  high while branch resolution is in progress.
- br_done  out  1  one-cycle pulse when branch resolution completes.
- br_taken  out  1  valid with br_done: 1 = PC was redirected.

Behaviour:
- Reset (clear high, asynchronous): pc=RESET_PC, state=IDLE, con_strobe=0, busy=0, br_done=0, br_taken=0, offset register=0.
- State IDLE:
  - br_req=1: latch offset; assert con_strobe this cycle (combinational from br_req while in IDLE); go to SETTLE; busy=1 from the next cycle.
  - inc_req=1 alone: pc <= pc + INC_STEP, mod 2^32 wrap; remain in IDLE; 1-cycle latency.
  - br_req and inc_req together: br_req wins; the increment is dropped.
- State SETTLE: one cycle for the CON flop to capture the condition; con_strobe=0; go to RESOLVE.
- State RESOLVE:
  - Sample con_flag.
  - If 1: pc <= pc + sign_extend(offset to 32 bits), mod 2^32 wrap.
  - If 0: pc unchanged.
  - Go to DONE.
- State DONE: br_done=1 and br_taken=sampled con_flag for exactly this cycle; busy=0; return to IDLE.
- Timing: total branch latency is 3 cycles from the br_req edge to the br_done pulse. The new PC is visible on pc in the DONE cycle.
- inc_req or br_req while busy (SETTLE/RESOLVE): ignored, with no queuing. The sequencer must not issue them.
- Offset 0 taken: pc unchanged but br_taken=1.
- Most negative offset (19'h40000) sign-extends to 32'hFFFC_0000.
- clear mid-branch: returns to IDLE immediately. No br_done is issued and pc=RESET_PC.
- br_taken holds its last value between br_done pulses. It is meaningful only when br_done=1.

Optional Feature:
- Macro: BRANCH_STATS_EN.
- When defined:
  - Adds ports taken_cnt out 16 and not_taken_cnt out 16.
  - Each counter increments in the DONE cycle according to br_taken.
  - Counters saturate at 16'hFFFF and clear on reset.
- When undefined: the ports and counters are absent and all other behaviour is identical.

Decomposition:
- Shared package: state enum (IDLE, SETTLE, RESOLVE, DONE), RESET_PC default, OFFSET_W default, and a sign-extend function from OFFSET_W to 32 bits.
- Sub-module: pc_reg, a 32-bit register with async clear to RESET_PC and a load enable.
  - The FSM and adder stay in branch_pc_unit.

Test Plan:
- Reset: clear=1 at any time -> pc=0, busy=0, br_done=0, con_strobe=0.
- Three inc_req pulses from pc=0 -> pc=1, 2, 3 on successive cycles. Wrap check: pc=32'hFFFF_FFFF plus inc -> 0.
- br_req with offset=19'd20, con_flag=1 at RESOLVE, pc=100:
  - con_strobe high in the req cycle.
  - br_done at cycle +3 with br_taken=1 and pc=120.
- br_req with offset=19'h7FFFF (-1), con_flag=1, pc=100 -> pc=99. Same request with con_flag=0 -> pc=100, br_taken=0.
- br_req and inc_req in the same cycle, pc=50, offset=4, con_flag=1 -> pc=54, with no increment applied. inc_req during SETTLE -> ignored.
- clear asserted in RESOLVE -> pc=RESET_PC, state IDLE, and no br_done.
- With BRANCH_STATS_EN: 2 taken and 1 not-taken branch -> taken_cnt=2, not_taken_cnt=1.

Source files
------------

// File: rtl/branch_pc_unit_pkg.sv
// Shared types and defaults for the branch/PC unit: FSM states, reset PC,
// branch displacement width and the displacement sign-extension helper.
package branch_pc_unit_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam int          OFFSET_W_DEF = 19;

    // Replicates bit (width-1) of a zero-extended field into all higher bits.
    function automatic logic [31:0] sign_extend(input logic [31:0] raw, input int width);
        logic [31:0] result;
        result = raw;
        for (int i = 0; i < 32; i++) begin
            if (i >= width) begin
                result[i] = raw[width-1];
            end
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_pc_unit_pc_reg.sv
// 32-bit program counter register with asynchronous clear to RESET_PC and a
// load enable.
module pc_reg #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/branch_pc_unit.sv
// Program counter owner and conditional branch resolver sitting after the CON
// flag stage. Optional taken/not-taken statistics: define BRANCH_STATS_EN.
module branch_pc_unit
    import branch_pc_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          OFFSET_W = OFFSET_W_DEF,
    parameter int          INC_STEP = 1
) (
    input  logic                clock,
    input  logic                clear,
    input  logic                inc_req,
    input  logic                br_req,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                con_flag,
    output logic                con_strobe,
    output logic [31:0]         pc,
    output logic                busy,
    output logic                br_done,
    output logic                br_taken
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]         taken_cnt,
    output logic [15:0]         not_taken_cnt
`endif
);

    state_t              state;
    state_t              state_next;
    logic [OFFSET_W-1:0] offset_q;
    logic                taken_q;
    logic                pc_load;
    logic [31:0]         pc_next;

    // State register plus the branch context captured alongside it.
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state    <= IDLE;
            offset_q <= '0;
            taken_q  <= 1'b0;
        end else begin
            state <= state_next;
            if (state == IDLE && br_req) begin
                offset_q <= offset;
            end
            if (state == RESOLVE) begin
                taken_q <= con_flag;
            end
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (br_req) state_next = SETTLE;
            SETTLE:  state_next = RESOLVE;
            RESOLVE: state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        con_strobe = (state == IDLE) && br_req;
        busy       = (state == SETTLE) || (state == RESOLVE);
        br_done    = (state == DONE);
        br_taken   = taken_q;
    end

    // A branch request in IDLE takes priority and drops a coincident increment.
    always_comb begin
        pc_load = 1'b0;
        pc_next = pc + 32'(INC_STEP);
        if (state == IDLE) begin
            pc_load = inc_req && !br_req;
        end else if (state == RESOLVE) begin
            pc_load = con_flag;
            pc_next = pc + sign_extend(32'(offset_q), OFFSET_W);
        end
    end

    pc_reg #(
        .RESET_PC(RESET_PC)
    ) u_pc_reg (
        .clock(clock),
        .clear(clear),
        .load (pc_load),
        .d    (pc_next),
        .q    (pc)
    );

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            taken_cnt     <= '0;
            not_taken_cnt <= '0;
        end else if (state == DONE) begin
            if (taken_q && taken_cnt != 16'hFFFF) begin
                taken_cnt <= taken_cnt + 16'd1;
            end
            if (!taken_q && not_taken_cnt != 16'hFFFF) begin
                not_taken_cnt <= not_taken_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_pc_unit.sv
// Self-checking bench for branch_pc_unit: directed literal cases followed by
// randomized traffic checked every cycle against a cycle-count reference model.
module tb_branch_pc_unit;

    logic        clock;
    logic        clear;
    logic        inc_req;
    logic        br_req;
    logic [18:0] offset;
    logic        con_flag;
    logic        con_strobe;
    logic [31:0] pc;
    logic        busy;
    logic        br_done;
    logic        br_taken;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_cnt;
    logic [15:0] not_taken_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    branch_pc_unit dut (
        .clock     (clock),
        .clear     (clear),
        .inc_req   (inc_req),
        .br_req    (br_req),
        .offset    (offset),
        .con_flag  (con_flag),
        .con_strobe(con_strobe),
        .pc        (pc),
        .busy      (busy),
        .br_done   (br_done),
        .br_taken  (br_taken)
`ifdef BRANCH_STATS_EN
        ,
        .taken_cnt    (taken_cnt),
        .not_taken_cnt(not_taken_cnt)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: m_since counts cycles since an accepted branch request
    // (-1 = none pending); the branch completes 3 cycles after acceptance.
    logic [31:0] m_pc;
    int          m_since;
    logic [18:0] m_off;
    logic        m_taken;
    logic [15:0] m_tc;
    logic [15:0] m_ntc;

    always @(posedge clock or posedge clear) begin
        if (clear) begin
            m_pc    <= 32'h0;
            m_since <= -1;
            m_off   <= '0;
            m_taken <= 1'b0;
            m_tc    <= '0;
            m_ntc   <= '0;
        end else begin
            case (m_since)
                1: m_since <= 2;
                2: begin
                    m_since <= 3;
                    m_taken <= con_flag;
                    if (con_flag) m_pc <= m_pc + {{13{m_off[18]}}, m_off};
                end
                3: begin
                    m_since <= -1;
                    if (m_taken) m_tc <= (m_tc == 16'hFFFF) ? m_tc : m_tc + 16'd1;
                    else         m_ntc <= (m_ntc == 16'hFFFF) ? m_ntc : m_ntc + 16'd1;
                end
                default: begin
                    if (br_req) begin
                        m_since <= 1;
                        m_off   <= offset;
                    end else if (inc_req) begin
                        m_pc <= m_pc + 32'd1;
                    end
                end
            endcase
        end
    end

    // Per-cycle comparison, sampled mid-low-phase after inputs have settled.
    always @(negedge clock) begin
        #2;
        check("pc", pc, m_pc);
        check("busy", 32'(busy), 32'(m_since == 1 || m_since == 2));
        check("br_done", 32'(br_done), 32'(m_since == 3));
        check("con_strobe", 32'(con_strobe), 32'(br_req && !(m_since >= 1 && m_since <= 3)));
        if (m_since == 3) check("br_taken", 32'(br_taken), 32'(m_taken));
`ifdef BRANCH_STATS_EN
        check("taken_cnt", 32'(taken_cnt), 32'(m_tc));
        check("not_taken_cnt", 32'(not_taken_cnt), 32'(m_ntc));
`endif
    end

    task automatic do_clear();
        @(negedge clock);
        clear = 1'b1;
        #2;
        check("clr_pc", pc, 32'h0);
        check("clr_busy", 32'(busy), 32'h0);
        check("clr_done", 32'(br_done), 32'h0);
        check("clr_strobe", 32'(con_strobe), 32'h0);
        @(negedge clock);
        clear = 1'b0;
    endtask

    task automatic do_branch(input string name, input logic [18:0] off, input logic flag,
                             input logic inc_same, input logic inc_settle,
                             input logic [31:0] exp_pc);
        @(negedge clock);
        br_req   = 1'b1;
        offset   = off;
        inc_req  = inc_same;
        con_flag = 1'($urandom);
        #2 check({name, "_strobe"}, 32'(con_strobe), 32'h1);
        @(negedge clock);
        br_req  = 1'b0;
        inc_req = inc_settle;
        offset  = 19'($urandom);
        #2 check({name, "_busy"}, 32'(busy), 32'h1);
        @(negedge clock);
        inc_req  = 1'b0;
        con_flag = flag;
        @(negedge clock);
        con_flag = 1'($urandom);
        #2;
        check({name, "_done"}, 32'(br_done), 32'h1);
        check({name, "_taken"}, 32'(br_taken), 32'(flag));
        check({name, "_pc"}, pc, exp_pc);
    endtask

    initial begin
        clear    = 1'b1;
        inc_req  = 1'b0;
        br_req   = 1'b0;
        offset   = '0;
        con_flag = 1'b0;
        #12;
        check("reset_pc", pc, 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_taken", 32'(br_taken), 32'h0);
        @(negedge clock);
        clear = 1'b0;

        // Three consecutive increments.
        @(negedge clock);
        inc_req = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clock);
            if (k == 3) inc_req = 1'b0;
            #2 check("inc_seq", pc, 32'(k));
        end

        // Reach 100, then taken +20 -> 120.
        do_clear();
        do_branch("setup100", 19'd100, 1'b1, 1'b0, 1'b0, 32'd100);
        do_branch("br_p20", 19'd20, 1'b1, 1'b0, 1'b0, 32'd120);

        // -1 taken and not taken from 100.
        do_clear();
        do_branch("setup100b", 19'd100, 1'b1, 1'b0, 1'b0, 32'd100);
        do_branch("br_m1", 19'h7FFFF, 1'b1, 1'b0, 1'b0, 32'd99);
        do_branch("br_m1_nt", 19'h7FFFF, 1'b0, 1'b0, 1'b0, 32'd99);

        // Offset 0 taken, most negative offset, wrap on increment.
        do_clear();
        do_branch("br_zero", 19'd0, 1'b1, 1'b0, 1'b0, 32'd0);
        do_branch("br_minneg", 19'h40000, 1'b1, 1'b0, 1'b0, 32'hFFFC_0000);
        do_clear();
        do_branch("to_max", 19'h7FFFF, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF);
        @(negedge clock);
        inc_req = 1'b1;
        @(negedge clock);
        inc_req = 1'b0;
        #2 check("inc_wrap", pc, 32'h0);

        // Coincident br_req/inc_req and inc_req during SETTLE are dropped.
        do_clear();
        do_branch("setup50", 19'd50, 1'b1, 1'b0, 1'b0, 32'd50);
        do_branch("br_inc_both", 19'd4, 1'b1, 1'b1, 1'b1, 32'd54);

        // Clear during RESOLVE: no br_done afterwards.
        do_clear();
        do_branch("setup7", 19'd7, 1'b1, 1'b0, 1'b0, 32'd7);
        @(negedge clock);
        br_req = 1'b1;
        offset = 19'd9;
        @(negedge clock);
        br_req = 1'b0;
        @(negedge clock);
        con_flag = 1'b1;
        clear    = 1'b1;
        #2;
        check("midclr_pc", pc, 32'h0);
        check("midclr_busy", 32'(busy), 32'h0);
        @(negedge clock);
        clear = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            #2 check("midclr_no_done", 32'(br_done), 32'h0);
        end

`ifdef BRANCH_STATS_EN
        do_clear();
        do_branch("st_t1", 19'd1, 1'b1, 1'b0, 1'b0, 32'd1);
        do_branch("st_n1", 19'd1, 1'b0, 1'b0, 1'b0, 32'd1);
        do_branch("st_t2", 19'd1, 1'b1, 1'b0, 1'b0, 32'd2);
        @(negedge clock);
        #2;
        check("stats_taken", 32'(taken_cnt), 32'd2);
        check("stats_not_taken", 32'(not_taken_cnt), 32'd1);
`endif

        // Randomized traffic checked by the per-cycle compare process.
        for (int n = 0; n < 3000; n++) begin
            @(negedge clock);
            con_flag = 1'($urandom);
            offset   = 19'($urandom);
            clear    = ($urandom_range(0, 199) == 0);
            if (m_since == 1 || m_since == 2) begin
                br_req  = ($urandom_range(0, 7) == 0);
                inc_req = ($urandom_range(0, 7) == 0);
            end else if (m_since == 3) begin
                br_req  = 1'b0;
                inc_req = 1'b0;
            end else begin
                int r;
                r = int'($urandom_range(0, 9));
                br_req  = (r < 3) || (r == 9);
                inc_req = (r >= 3 && r < 7) || (r == 9);
            end
        end
        @(negedge clock);
        clear   = 1'b0;
        br_req  = 1'b0;
        inc_req = 1'b0;
        repeat (4) @(negedge clock);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
